stopwatch_bcd_core: RTL
=======================

// Module: stopwatch_bcd_core
// PURPOSE
//  Time base and BCD digit counter for the Swiss timer. Runs an MM:SS.hh stopwatch
//  from the system clock and presents six 4-bit BCD digits, one per 7-segment
//  decoder. Sits directly upstream of the per-digit hex-to-segment translators.
//  Command inputs are single-cycle synchronous pulses, already debounced upstream.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency in Hz
//  TICK_HZ  100         count rate in Hz (hundredths of a second)
//  DIV      = CLK_HZ/TICK_HZ (localparam). Must be >= 2; the prescaler is $clog2(DIV) bits.
// PORTS
//  clk          in   1  system clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  start_stop   in   1  pulse: toggle run/pause
//  clear        in   1  pulse: zero all digits and return to IDLE
//  lap          in   1  pulse: toggle lap hold (only with LAP_HOLD_EN)
//  digit_mt     out  4  minutes tens, BCD 0-5
//  digit_mo     out  4  minutes ones, BCD 0-9
//  digit_st     out  4  seconds tens, BCD 0-5
//  digit_so     out  4  seconds ones, BCD 0-9
//  digit_ht     out  4  hundredths tens, BCD 0-9
//  digit_ho     out  4  hundredths ones, BCD 0-9
//  running      out  1  1 while in RUNNING
//  overflow     out  1  sticky; set on wrap past 59:59.99
// BEHAVIOUR
//  - Reset: state=IDLE; prescaler=0; all digits=0; running=0; overflow=0.
//  - FSM states:
//    - IDLE: start_stop -> RUNNING.
//    - RUNNING: start_stop -> PAUSED.
//    - PAUSED: start_stop -> RUNNING.
//    - Any state: clear -> IDLE.
//  - Priority: clear beats start_stop and lap in the same cycle. Clear zeroes the
//    prescaler, digits, overflow and lap hold. If clear and start_stop arrive
//    together, the result is IDLE, not RUNNING.
//  - Prescaler: counts only in RUNNING. Counts 0..DIV-1 and wraps to 0.
//    - tick = (prescaler==DIV-1) && RUNNING.
//    - In PAUSED the prescaler holds its value, so a resumed run completes the
//      partial period.
//  - BCD chain, advanced on tick with a ripple carry inside the same cycle:
//    - ho 9->0 carries into ht; ht 9->0 carries into so; so 9->0 carries into st.
//    - st 5->0 carries into mo; mo 9->0 carries into mt; mt 5->0 sets overflow.
//    - 59:59.99 + tick -> 00:00.00, overflow=1. Counting continues; overflow stays
//      set until clear or reset.
//  - Digits are registered. They update on the clock edge that samples tick,
//    1 cycle after prescaler==DIV-1 is reached. Non-BCD values never appear.
//  - running is registered and equals (state==RUNNING) from the cycle after the
//    transition.
//  - start_stop on the same edge as tick: that tick is still counted and the
//    pause takes effect afterwards.
//  - reset_n asserted mid-count: all outputs go to their reset values
//    asynchronously. Release is synchronous to clk; the first count needs
//    start_stop.
// CONFIGURATION
//  LAP_HOLD_EN defined:
//   - A lap_hold register toggles on lap, only while in RUNNING or PAUSED; it is
//     ignored in IDLE.
//   - While lap_hold=1, the digit_* outputs hold a snapshot taken on the lap edge.
//     The internal counter keeps running and overflow still tracks it.
//   - A second lap releases the hold; the digits show the live count on the next
//     cycle.
//   - clear forces lap_hold=0.
//  LAP_HOLD_EN undefined:
//   - lap is ignored; no snapshot registers are built; digit_* always show the live
//     count.
// TESTING (bench uses CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//  1. Reset, pulse start_stop, run 100 clks -> ho=9, others 0, running=1.
//     Clk 101 -> ht=1, ho=0.
//  2. Run 35 clks, pulse start_stop (pause), wait 50 clks, resume, run 5 clks ->
//     ho=4 exactly. Prescaler held through the pause.
//  3. Preload to 59:59.99 via force, run 10 clks -> all digits 0, overflow=1.
//     After a further 10 clks overflow is still 1. Pulse clear -> overflow=0,
//     running=0.
//  4. clear and start_stop in the same cycle while RUNNING -> IDLE, digits 0,
//     running=0. Next start_stop -> RUNNING.
//  5. Assert reset_n low for 3 clks mid-count at 00:12.34 -> outputs 0
//     immediately, without waiting for a clk edge. After release no counting
//     until start_stop.
//  6. (LAP_HOLD_EN) Lap at 00:00.03, run 50 clks -> digits still 00:00.03.
//     Lap again -> digits 00:00.08 next cycle.

Source files
------------

// File: rtl/stopwatch_bcd_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_bcd_core
// Summary  : MM:SS.hh stopwatch time base with six-digit BCD ripple counter.
//            Optional lap snapshot display enabled by defining LAP_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_bcd_core #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit_mt,
  output logic [3:0] digit_mo,
  output logic [3:0] digit_st,
  output logic [3:0] digit_so,
  output logic [3:0] digit_ht,
  output logic [3:0] digit_ho,
  output logic       running,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_mt, r_mo, r_st, r_so, r_ht, r_ho;
  logic          r_running;
  logic          r_overflow;

  logic w_tick;
  logic w_c_ho, w_c_ht, w_c_so, w_c_st, w_c_mo, w_wrap;

  // Carry into each digit is qualified by every lower digit being at its maximum.
  assign w_tick = (r_state == S_RUNNING) && (r_presc == PRESC_LAST);
  assign w_c_ho = w_tick && (r_ho == 4'd9);
  assign w_c_ht = w_c_ho && (r_ht == 4'd9);
  assign w_c_so = w_c_ht && (r_so == 4'd9);
  assign w_c_st = w_c_so && (r_st == 4'd5);
  assign w_c_mo = w_c_st && (r_mo == 4'd9);
  assign w_wrap = w_c_mo && (r_mt == 4'd5);

  function automatic logic [3:0] f_bcd_next(input logic [3:0] d, input logic en,
                                            input logic [3:0] max);
    if (!en)
      return d;
    else if (d == max)
      return 4'd0;
    else
      return d + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_mt       <= 4'd0;
      r_mo       <= 4'd0;
      r_st       <= 4'd0;
      r_so       <= 4'd0;
      r_ht       <= 4'd0;
      r_ho       <= 4'd0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_mt       <= 4'd0;
      r_mo       <= 4'd0;
      r_st       <= 4'd0;
      r_so       <= 4'd0;
      r_ht       <= 4'd0;
      r_ho       <= 4'd0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_stop) begin
            r_state   <= S_RUNNING;
            r_running <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (start_stop) begin
            r_state   <= S_PAUSED;
            r_running <= 1'b0;
          end
        end
        S_PAUSED: begin
          if (start_stop) begin
            r_state   <= S_RUNNING;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase

      // A pause on the tick edge still counts that tick: both act on the old state.
      if (r_state == S_RUNNING)
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;

      r_ho <= f_bcd_next(r_ho, w_tick, 4'd9);
      r_ht <= f_bcd_next(r_ht, w_c_ho, 4'd9);
      r_so <= f_bcd_next(r_so, w_c_ht, 4'd9);
      r_st <= f_bcd_next(r_st, w_c_so, 4'd5);
      r_mo <= f_bcd_next(r_mo, w_c_st, 4'd9);
      r_mt <= f_bcd_next(r_mt, w_c_mo, 4'd5);

      if (w_wrap)
        r_overflow <= 1'b1;
    end
  end

  assign running  = r_running;
  assign overflow = r_overflow;

`ifdef LAP_HOLD_EN
  logic       r_lap_hold;
  logic [3:0] r_snap_mt, r_snap_mo, r_snap_st, r_snap_so, r_snap_ht, r_snap_ho;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lap_hold <= 1'b0;
      r_snap_mt  <= 4'd0;
      r_snap_mo  <= 4'd0;
      r_snap_st  <= 4'd0;
      r_snap_so  <= 4'd0;
      r_snap_ht  <= 4'd0;
      r_snap_ho  <= 4'd0;
    end else if (clear) begin
      r_lap_hold <= 1'b0;
    end else if (lap && (r_state != S_IDLE)) begin
      r_lap_hold <= ~r_lap_hold;
      if (!r_lap_hold) begin
        r_snap_mt <= r_mt;
        r_snap_mo <= r_mo;
        r_snap_st <= r_st;
        r_snap_so <= r_so;
        r_snap_ht <= r_ht;
        r_snap_ho <= r_ho;
      end
    end
  end

  assign digit_mt = r_lap_hold ? r_snap_mt : r_mt;
  assign digit_mo = r_lap_hold ? r_snap_mo : r_mo;
  assign digit_st = r_lap_hold ? r_snap_st : r_st;
  assign digit_so = r_lap_hold ? r_snap_so : r_so;
  assign digit_ht = r_lap_hold ? r_snap_ht : r_ht;
  assign digit_ho = r_lap_hold ? r_snap_ho : r_ho;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;

  assign digit_mt = r_mt;
  assign digit_mo = r_mo;
  assign digit_st = r_st;
  assign digit_so = r_so;
  assign digit_ht = r_ht;
  assign digit_ho = r_ho;
`endif

endmodule
`default_nettype wire
